// File: rtl/microc_ctrl_if.sv
// Bus between the microc sequencing control unit and its stimulus/datapath side.
// Groups the opcode/flag/command inputs and the control word, status and
// debug outputs. The clock and reset stay outside as plain ports.
interface microc_ctrl_if #(
  parameter int CNT_W = 16
);
  // Command semantics: start, step and stop are levels sampled at each rising
  // clock edge. There is no ready/accept signal, because the controller
  // always samples them. Commands that do not apply in the current state are
  // ignored. The control word is valid in the same cycle as opcode/z and
  // takes effect at the next rising edge.
  logic [5:0]       opcode;
  logic             z;
  logic             start;
  logic             step;
  logic             stop;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       op;
  logic             pc_en;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [1:0]       state;

  // Stimulus/datapath side
  modport master (
    output opcode, z, start, step, stop,
    input  s_inc, s_inm, we3, wez, op, pc_en, halted, illegal, instr_cnt, state
  );

  // Controller side
  modport slave (
    input  opcode, z, start, step, stop,
    output s_inc, s_inm, we3, wez, op, pc_en, halted, illegal, instr_cnt, state
  );
endinterface

// File: rtl/microc_ctrl.sv
// microc sequencing control unit.
// Decodes opcode and z into the datapath control word. A run/step/stop/halt
// state machine gates execution. The unit also keeps a sticky illegal-opcode
// flag and a saturating count of retired instructions.
module microc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  microc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic executing;
  logic is_halt;
  logic is_legal;

  assign executing = (state == RUN) || (state == STEP);
  assign is_halt   = (bus.opcode == 6'b111111);

  // Opcode decode. Control is Mealy and executes only in RUN/STEP. Outside
  // those states the word is inert (PC held, no writes). Because of this,
  // the async reset clears the outputs as soon as it drops the state to IDLE.
  always_comb begin
    bus.s_inc = 1'b1;
    bus.s_inm = 1'b0;
    bus.we3   = 1'b0;
    bus.wez   = 1'b0;
    bus.op    = 3'b000;
    bus.pc_en = 1'b0;
    is_legal  = 1'b1;
    if (executing) begin
      casez (bus.opcode)
        6'b00????: begin
          bus.we3   = 1'b1;
          bus.wez   = 1'b1;
          bus.op    = bus.opcode[3:1];
          bus.pc_en = 1'b1;
        end
        6'b010000: begin
          bus.s_inm = 1'b1;
          bus.we3   = 1'b1;
          bus.pc_en = 1'b1;
        end
        6'b100000: begin
          bus.s_inc = 1'b0;
          bus.pc_en = 1'b1;
        end
        6'b100001: begin
          bus.s_inc = ~bus.z;
          bus.pc_en = 1'b1;
        end
        6'b100010: begin
          bus.s_inc = bus.z;
          bus.pc_en = 1'b1;
        end
        6'b110000: begin
          bus.pc_en = 1'b1;
        end
        6'b111111: begin
          // PC stays on the halt instruction. The don't-care select is driven 0.
          bus.s_inc = 1'b0;
        end
        default: begin
          // An undefined code behaves as a nop and is flagged.
          bus.pc_en = 1'b1;
          is_legal  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer: state transitions, the halted flag, the sticky illegal flag
  // and the saturating retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
          end else if (bus.step) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (is_halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else if (bus.stop) begin
            state <= IDLE;
          end
        end
        STEP: begin
          if (is_halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALTED: begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (executing && !is_legal) begin
        illegal_q <= 1'b1;
      end
      if (executing && !is_halt && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_microc_ctrl.sv
// Directed bench for microc_ctrl: one full-width instance and one CNT_W=3
// instance for counter saturation. The control word is packed as
// {s_inc, s_inm, we3, wez, op[2:0], pc_en}.
module tb_microc_ctrl;

  localparam logic [7:0] W_IDLE = 8'b1_0_0_0_000_0;
  localparam logic [7:0] W_JMP  = 8'b0_0_0_0_000_1;
  localparam logic [7:0] W_LI   = 8'b1_1_1_0_000_1;
  localparam logic [7:0] W_A010 = 8'b1_0_1_1_010_1;
  localparam logic [7:0] W_A011 = 8'b1_0_1_1_011_1;
  localparam logic [7:0] W_NOP  = 8'b1_0_0_0_000_1;
  localparam logic [7:0] W_HALT = 8'b0_0_0_0_000_0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  microc_ctrl_if #(.CNT_W(16)) b  ();
  microc_ctrl_if #(.CNT_W(3))  b3 ();

  microc_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  microc_ctrl #(.CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
  );

  logic [7:0] ctrl;
  assign ctrl = {b.s_inc, b.s_inm, b.we3, b.wez, b.op, b.pc_en};

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] opc, input logic zz, input logic st, input logic sp,
                       input logic so);
    b.opcode = opc;
    b.z      = zz;
    b.start  = st;
    b.step   = sp;
    b.stop   = so;
  endtask

  logic [5:0] prog_op [8];
  logic [7:0] prog_w  [8];

  initial begin
    total = 0;
    bad   = 0;
    prog_op = '{6'b100000, 6'b010000, 6'b010000, 6'b010000, 6'b010000,
                6'b000100, 6'b000110, 6'b100010};
    prog_w  = '{W_JMP, W_LI, W_LI, W_LI, W_LI, W_A010, W_A011, W_JMP};

    reset = 1'b1;
    drive(6'b000100, 1'b0, 1'b0, 1'b0, 1'b0);
    b3.opcode = 6'b110000;
    b3.z      = 1'b0;
    b3.start  = 1'b0;
    b3.step   = 1'b0;
    b3.stop   = 1'b0;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(W_IDLE));
    chk("rst_cnt", 32'(b.instr_cnt), 32'd0);
    chk("rst_state", 32'(b.state), 32'(S_IDLE));
    #10;
    reset = 1'b0;

    // Idle with an ALU opcode present: nothing executes.
    for (int i = 0; i < 3; i++) begin
      chk("idle_ctrl", 32'(ctrl), 32'(W_IDLE));
      chk("idle_cnt", 32'(b.instr_cnt), 32'd0);
      chk("idle_halted", 32'(b.halted), 32'd0);
      tick();
    end

    // Start, then run the program.
    drive(6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_ctrl", 32'(ctrl), 32'(W_IDLE));
    tick();
    chk("start_state", 32'(b.state), 32'(S_RUN));
    for (int i = 0; i < 8; i++) begin
      drive(prog_op[i], 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("prog_%0d", i), 32'(ctrl), 32'(prog_w[i]));
      tick();
    end
    chk("prog_cnt", 32'(b.instr_cnt), 32'd8);

    // Conditional branches.
    drive(6'b100010, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("jnz_z1", 32'(ctrl), 32'(W_NOP));
    tick();
    drive(6'b100001, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("jz_z1", 32'(ctrl), 32'(W_JMP));
    tick();
    drive(6'b100001, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("jz_z0", 32'(ctrl), 32'(W_NOP));
    tick();
    chk("br_cnt", 32'(b.instr_cnt), 32'd11);

    // Stop with an ALU opcode: the write still happens, then IDLE.
    drive(6'b000100, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("stop_alu", 32'(ctrl), 32'(W_A010));
    tick();
    drive(6'b010000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_state", 32'(b.state), 32'(S_IDLE));
    chk("stop_cnt", 32'(b.instr_cnt), 32'd12);
    chk("stop_idle_ctrl", 32'(ctrl), 32'(W_IDLE));

    // Single step of li. start is asserted during STEP and must be ignored.
    b.step = 1'b1;
    tick();
    b.step  = 1'b0;
    b.start = 1'b1;
    #1;
    chk("step_state", 32'(b.state), 32'(S_STEP));
    chk("step_ctrl", 32'(ctrl), 32'(W_LI));
    tick();
    b.start = 1'b0;
    chk("step_after_state", 32'(b.state), 32'(S_IDLE));
    chk("step_after_ctrl", 32'(ctrl), 32'(W_IDLE));
    chk("step_cnt", 32'(b.instr_cnt), 32'd13);

    // Illegal opcode in RUN, then halt with stop (halt wins).
    b.start = 1'b1;
    tick();
    drive(6'b101010, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ill_ctrl", 32'(ctrl), 32'(W_NOP));
    chk("ill_before", 32'(b.illegal), 32'd0);
    tick();
    chk("ill_after", 32'(b.illegal), 32'd1);
    drive(6'b111111, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("halt_ctrl", 32'(ctrl), 32'(W_HALT));
    tick();
    chk("halt_state", 32'(b.state), 32'(S_HALTED));
    chk("halt_flag", 32'(b.halted), 32'd1);
    chk("halt_ctrl_idle", 32'(ctrl), 32'(W_IDLE));
    chk("halt_cnt", 32'(b.instr_cnt), 32'd14);
    drive(6'b000100, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("halt_absorb", 32'(b.state), 32'(S_HALTED));
    chk("halt_absorb_cnt", 32'(b.instr_cnt), 32'd14);
    chk("halt_still_ill", 32'(b.illegal), 32'd1);

    // Asynchronous reset clears status without a clock edge.
    drive(6'b000110, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_halted", 32'(b.halted), 32'd0);
    chk("areset_illegal", 32'(b.illegal), 32'd0);
    chk("areset_cnt", 32'(b.instr_cnt), 32'd0);
    #2;
    reset = 1'b0;

    // Reset mid-RUN forces the control word inert immediately.
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    #1;
    chk("mid_run_ctrl", 32'(ctrl), 32'(W_A011));
    reset = 1'b1;
    #1;
    chk("mid_reset_ctrl", 32'(ctrl), 32'(W_IDLE));
    chk("mid_reset_state", 32'(b.state), 32'(S_IDLE));
    #2;
    reset = 1'b0;

    // Saturation on the 3-bit counter.
    b3.start = 1'b1;
    tick();
    b3.start = 1'b0;
    chk("sat_state", 32'(b3.state), 32'(S_RUN));
    repeat (6) tick();
    chk("sat_cnt6", 32'(b3.instr_cnt), 32'd6);
    tick();
    chk("sat_cnt7", 32'(b3.instr_cnt), 32'd7);
    repeat (3) tick();
    chk("sat_cnt10", 32'(b3.instr_cnt), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
